// File: rtl/enigma_rotor.sv
// One Enigma rotor: a fixed wiring permutation seen through a rotating
// offset, plus the window position / ring setting registers and the notch flag.
module enigma_rotor #(
    parameter logic [26*8-1:0] WIRING = "EKMFLGDQVZNTOWYHXUSPAIBRCJ",
    parameter logic [7:0]      NOTCH  = "Q"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [4:0]  load_pos,
    input  logic [4:0]  load_ring,
    input  logic        step,
    output logic [4:0]  pos,
    output logic [4:0]  ring,
    output logic        at_notch,
    input  logic [25:0] fwd_in,
    output logic [25:0] fwd_out,
    input  logic [25:0] bwd_in,
    output logic [25:0] bwd_out
);

    localparam logic [4:0] NOTCH_IDX = 5'(NOTCH - 8'd65);

    // Character k of the string sits in the most significant bytes first.
    function automatic logic [4:0] wire_of(input int e);
        logic [7:0] c;
        c = WIRING[8*(25-e) +: 8];
        return 5'(c - 8'd65);
    endfunction

    function automatic logic [4:0] inv_of(input int e);
        logic [4:0] r;
        r = 5'd0;
        for (int k = 0; k < 26; k++) begin
            if (wire_of(k) == 5'(e)) r = 5'(k);
        end
        return r;
    endfunction

    function automatic logic [4:0] wrap26(input logic [4:0] v);
        return (v >= 5'd26) ? v - 5'd26 : v;
    endfunction

    // out[k] = x[(k - s) mod 26]
    function automatic logic [25:0] rotl26(input logic [25:0] x, input logic [4:0] s);
        logic [51:0] y;
        y = {x, x};
        y = y >> (6'd26 - {1'b0, s});
        return y[25:0];
    endfunction

    // out[k] = x[(k + s) mod 26]
    function automatic logic [25:0] rotr26(input logic [25:0] x, input logic [4:0] s);
        logic [51:0] y;
        y = {x, x};
        y = y >> {1'b0, s};
        return y[25:0];
    endfunction

    logic [4:0] pos_reg, pos_next;
    logic [4:0] ring_reg, ring_next;

    always_comb begin
        pos_next  = pos_reg;
        ring_next = ring_reg;
        if (load) begin
            pos_next  = wrap26(load_pos);
            ring_next = wrap26(load_ring);
        end else if (step) begin
            pos_next = (pos_reg == 5'd25) ? 5'd0 : pos_reg + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_reg  <= 5'd0;
            ring_reg <= 5'd0;
        end else begin
            pos_reg  <= pos_next;
            ring_reg <= ring_next;
        end
    end

    assign pos      = pos_reg;
    assign ring     = ring_reg;
    assign at_notch = (pos_reg == NOTCH_IDX);

    // When pos < ring the 5-bit difference wraps mod 32; adding 26 lands it back in 0..25.
    logic [4:0] offset;
    assign offset = (pos_reg >= ring_reg) ? pos_reg - ring_reg : pos_reg - ring_reg + 5'd26;

    logic [25:0] fwd_rot, fwd_wired, bwd_rot, bwd_wired;

    assign fwd_rot = rotl26(fwd_in, offset);
    assign bwd_rot = rotl26(bwd_in, offset);

    // Fixed wiring written in gather form so every output bit has exactly one source.
    for (genvar gi = 0; gi < 26; gi++) begin : g_wiring
        localparam logic [4:0] W_IDX   = wire_of(gi);
        localparam logic [4:0] INV_IDX = inv_of(gi);
        assign fwd_wired[gi] = fwd_rot[INV_IDX];
        assign bwd_wired[gi] = bwd_rot[W_IDX];
    end

    assign fwd_out = rotr26(fwd_wired, offset);
    assign bwd_out = rotr26(bwd_wired, offset);

endmodule

// File: tb/tb_enigma_rotor.sv
// Bench for enigma_rotor: directed vector table, inverse sweep, reset corner
// cases and a random run against a letter-level rotor model.
module tb_enigma_rotor;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [4:0]  load_pos;
    logic [4:0]  load_ring;
    logic        step;
    logic [4:0]  pos;
    logic [4:0]  ring;
    logic        at_notch;
    logic [25:0] fwd_in;
    logic [25:0] fwd_out;
    logic [25:0] bwd_in;
    logic [25:0] bwd_out;

    int vectors = 0;
    int miscompares = 0;

    string wir = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    int    notch_idx = 16;

    enigma_rotor dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_pos  (load_pos),
        .load_ring (load_ring),
        .step      (step),
        .pos       (pos),
        .ring      (ring),
        .at_notch  (at_notch),
        .fwd_in    (fwd_in),
        .fwd_out   (fwd_out),
        .bwd_in    (bwd_in),
        .bwd_out   (bwd_out)
    );

    always #5 clk = ~clk;

    function automatic int m26(input int v);
        return ((v % 26) + 26) % 26;
    endfunction

    function automatic logic [25:0] model_fwd(input logic [25:0] x, input int s);
        logic [25:0] o;
        int w;
        o = '0;
        for (int i = 0; i < 26; i++) begin
            if (x[i]) begin
                w = int'(wir[m26(i + s)]) - 65;
                o[m26(w - s)] = 1'b1;
            end
        end
        return o;
    endfunction

    function automatic logic [25:0] model_bwd(input logic [25:0] x, input int s);
        logic [25:0] o;
        int e, w;
        o = '0;
        for (int j = 0; j < 26; j++) begin
            if (x[j]) begin
                e = m26(j + s);
                w = 0;
                for (int k = 0; k < 26; k++) if (int'(wir[k]) - 65 == e) w = k;
                o[m26(w - s)] = 1'b1;
            end
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs are changed 1 time unit after a rising edge, outputs sampled 1 unit after.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        ld;
        logic [4:0]  lp;
        logic [4:0]  lr;
        logic        st;
        logic [25:0] fi;
        logic [25:0] bi;
        logic [4:0]  e_pos;
        logic [4:0]  e_ring;
        logic        e_notch;
        logic [25:0] e_fwd;
        logic [25:0] e_bwd;
    } vec_t;

    vec_t tbl[12];

    int mp, mr, s;
    logic [25:0] r_f, r_b;

    initial begin
        // {ld, lp, lr, st, fwd_in, bwd_in, pos, ring, notch, fwd_out, bwd_out}
        tbl[0]  = '{0, 0,  0,  0, 26'h1,  26'h10,  0,  0, 0, 26'h10,  26'h1};
        tbl[1]  = '{0, 0,  0,  1, 26'h1,  26'h200, 1,  0, 0, 26'h200, 26'h1};
        tbl[2]  = '{1, 15, 0,  0, 26'h0,  26'h0,   15, 0, 0, 26'h0,   26'h0};
        tbl[3]  = '{0, 0,  0,  1, 26'h0,  26'h0,   16, 0, 1, 26'h0,   26'h0};
        tbl[4]  = '{0, 0,  0,  1, 26'h0,  26'h0,   17, 0, 0, 26'h0,   26'h0};
        tbl[5]  = '{1, 25, 0,  0, 26'h0,  26'h0,   25, 0, 0, 26'h0,   26'h0};
        tbl[6]  = '{0, 0,  0,  1, 26'h0,  26'h0,   0,  0, 0, 26'h0,   26'h0};
        tbl[7]  = '{1, 28, 0,  0, 26'h0,  26'h0,   2,  0, 0, 26'h0,   26'h0};
        tbl[8]  = '{1, 7,  0,  1, 26'h0,  26'h0,   7,  0, 0, 26'h0,   26'h0};
        tbl[9]  = '{1, 0,  1,  0, 26'h1,  26'h400, 0,  1, 0, 26'h400, 26'h1};
        tbl[10] = '{0, 0,  0,  0, 26'h3,  26'h0,   0,  1, 0, 26'h420, 26'h0};
        tbl[11] = '{1, 30, 31, 0, 26'h1,  26'h0,   4,  5, 0, 26'h400, 26'h0};

        reset = 1'b1; load = 0; load_pos = 0; load_ring = 0; step = 0;
        fwd_in = 0; bwd_in = 0;
        tick; tick;
        check("reset_pos", 26'(pos), 26'd0);
        check("reset_ring", 26'(ring), 26'd0);
        check("reset_notch", 26'(at_notch), 26'd0);
        reset = 1'b0;

        for (int v = 0; v < 12; v++) begin
            load = tbl[v].ld; load_pos = tbl[v].lp; load_ring = tbl[v].lr;
            step = tbl[v].st; fwd_in = tbl[v].fi; bwd_in = tbl[v].bi;
            tick;
            load = 0; step = 0;
            check($sformatf("tbl%0d_pos", v), 26'(pos), 26'(tbl[v].e_pos));
            check($sformatf("tbl%0d_ring", v), 26'(ring), 26'(tbl[v].e_ring));
            check($sformatf("tbl%0d_notch", v), 26'(at_notch), 26'(tbl[v].e_notch));
            check($sformatf("tbl%0d_fwd", v), fwd_out, tbl[v].e_fwd);
            check($sformatf("tbl%0d_bwd", v), bwd_out, tbl[v].e_bwd);
        end
        check("multihot_popcount", 26'($countones(fwd_out)), 26'd1);

        // Inverse sweep: every letter at every position, ring varied.
        for (int p = 0; p < 26; p++) begin
            load = 1; load_pos = 5'(p); load_ring = 5'((p * 7) % 26);
            tick;
            load = 0;
            s = m26(p - (p * 7) % 26);
            for (int x = 0; x < 26; x++) begin
                fwd_in = 26'(1) << x;
                #1;
                check($sformatf("sweep_fwd_p%0d_x%0d", p, x), fwd_out, model_fwd(fwd_in, s));
                bwd_in = fwd_out;
                #1;
                check($sformatf("sweep_inv_p%0d_x%0d", p, x), bwd_out, 26'(1) << x);
            end
        end
        fwd_in = 0; bwd_in = 0;

        // Held step: N cycles give N steps.
        load = 1; load_pos = 5'd3; load_ring = 5'd0;
        tick;
        load = 0; step = 1;
        repeat (5) tick;
        step = 0;
        check("held_step_pos", 26'(pos), 26'd8);

        // Asynchronous reset between edges.
        load = 1; load_pos = 5'd12; load_ring = 5'd3;
        tick;
        load = 0;
        check("pre_async_pos", 26'(pos), 26'd12);
        #2 reset = 1'b1;
        #1;
        check("async_pos", 26'(pos), 26'd0);
        check("async_ring", 26'(ring), 26'd0);
        // Reset held across an edge overrides load and step.
        load = 1; load_pos = 5'd9; load_ring = 5'd9; step = 1;
        tick;
        check("reset_over_load", 26'(pos), 26'd0);
        load = 0; step = 0; reset = 1'b0;
        tick;

        // Random run against the model.
        mp = 0; mr = 0;
        for (int n = 0; n < 400; n++) begin
            load = ($urandom_range(0, 7) == 0);
            step = $urandom_range(0, 1);
            load_pos = 5'($urandom_range(0, 31));
            load_ring = 5'($urandom_range(0, 31));
            r_f = 26'($urandom);
            r_b = 26'($urandom);
            fwd_in = ($urandom_range(0, 1) == 1) ? (26'(1) << $urandom_range(0, 25)) : r_f;
            bwd_in = ($urandom_range(0, 1) == 1) ? (26'(1) << $urandom_range(0, 25)) : r_b;
            tick;
            if (load) begin
                mp = int'(load_pos) % 26;
                mr = int'(load_ring) % 26;
            end else if (step) begin
                mp = (mp + 1) % 26;
            end
            load = 0; step = 0;
            s = m26(mp - mr);
            check($sformatf("rnd%0d_pos", n), 26'(pos), 26'(mp));
            check($sformatf("rnd%0d_ring", n), 26'(ring), 26'(mr));
            check($sformatf("rnd%0d_notch", n), 26'(at_notch), 26'(mp == notch_idx));
            check($sformatf("rnd%0d_fwd", n), fwd_out, model_fwd(fwd_in, s));
            check($sformatf("rnd%0d_bwd", n), bwd_out, model_bwd(bwd_in, s));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/enigma_rotor.md
Name: enigma_rotor

Overview:
- One Enigma rotor: a wiring permutation plus a 5-bit rotor position register with ring setting, turnover notch detection, load and step.
- Letters are carried as 26-bit one-hot vectors; bit k = letter 'A'+k, the same encoding the reflector uses.
- Three instances are chained in front of the reflector. The leftmost rotor's fwd_out drives reflector in; reflector out returns into that rotor's bwd_in.
- External stepping logic (double-step included) uses at_notch from each instance to generate the step pulses.

Parameters:
- WIRING, "EKMFLGDQVZNTOWYHXUSPAIBRCJ", 26-char ASCII string; char k (leftmost = k 0) is the contact that entry contact k is wired to at zero offset. Default is rotor I.
- NOTCH, "Q", single ASCII char; the window letter at which this rotor signals turnover.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- load  input  1  load position and ring setting this cycle
- load_pos  input  5  new window position, 0..25
- load_ring  input  5  new ring setting, 0..25
- step  input  1  single-cycle step request
- pos  output  5  current window position (0 = 'A')
- ring  output  5  current ring setting
- at_notch  output  1  high while pos equals NOTCH-'A'
- fwd_in  input  26  one-hot letter entering from the right (keyboard side)
- fwd_out  output  26  one-hot letter leaving toward the left / reflector
- bwd_in  input  26  one-hot letter returning from the left / reflector
- bwd_out  output  26  one-hot letter leaving toward the right (lamp side)

Behaviour:
- Reset, asynchronous and active-high: pos=0, ring=0, at_notch = (NOTCH=='A'). Reset asserted mid-operation overrides load and step immediately.
- Per rising edge, priority is load > step > hold.
  - load=1: pos <= load_pos mod 26, ring <= load_ring mod 26. Values 26..31 reduce by 26 (26 becomes 0). step is ignored that cycle.
  - step=1 and load=0: pos <= pos+1, wrapping 25 to 0. ring unchanged.
  - step held high for N cycles produces N steps; step is level-sampled per clock.
- at_notch is combinational from pos. It goes high one cycle after the step that lands on the notch and drops on the next step.
- Offset s = (pos - ring) mod 26, range 0..25. All arithmetic is modulo 26 in 5-bit values with explicit wrap, never mod 32.
- Forward path, combinational from fwd_in and s: for each bit i, e = (i+s) mod 26, w = WIRING[e]-'A', and fwd_out[(w-s) mod 26] = fwd_in[i].
- Backward path is the exact inverse: for each bit j, e = (j+s) mod 26, w = index of letter e in WIRING, and bwd_out[(w-s) mod 26] = bwd_in[j].
- Both paths are pure wire permutations.
  - Zero input gives zero output.
  - A multi-hot input gives a multi-hot output with the same popcount.
  - No latch inferred; every fwd_out and bwd_out bit is assigned on every evaluation.
- Both paths see the new pos in the cycle after a step or load edge. An encipherment issued with a keypress step is valid from the following cycle.
- WIRING must be a permutation of A..Z. The inverse table is derived at elaboration, not hand-entered.

Test Plan:
- Reset, then fwd_in=bit0 (A) -> fwd_out=bit4 (E); bwd_in=bit4 -> bwd_out=bit0; pos=0, ring=0, at_notch=0.
- One step pulse, then fwd_in=bit0 -> pos=1, fwd_out=bit9 (J). Sweep all 26 fwd_in bits at each of 26 positions; bwd(fwd(x))==x must hold for every x.
- load pos=15, then step -> pos=16, at_notch=1; step again -> pos=17, at_notch=0.
- load pos=25, then step -> pos=0 (wrap). load_pos=28 -> pos=2. load and step high in the same cycle with load_pos=7 -> pos=7.
- load ring=1, pos=0, then fwd_in=bit0 -> fwd_out=bit10 (K). fwd_in=0 -> fwd_out=0. fwd_in=bits0|1 -> exactly 2 bits set in fwd_out.
- Assert reset asynchronously between edges with pos=12, ring=3 -> pos=0 and ring=0 immediately, before the next clock edge.
